// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encodings for the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_E0,
    B_F0,
    B_E0F0
  } byte_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronizers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop checking, and an inter-edge timeout that silently aborts.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_error
);

  logic                 r_clk_s1, r_clk_s2, r_clk_prev;
  logic                 r_dat_s1, r_dat_s2;
  rx_state_t            r_state, w_state_nxt;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shift;
  logic                 r_par_ok;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic                 r_byte_valid, r_frame_error;
  logic                 w_byte_valid_nxt, w_frame_error_nxt;
  logic                 w_fall, w_timeout;

  assign w_fall    = r_clk_prev & ~r_clk_s2;
  assign w_timeout = (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_state_nxt       = r_state;
    w_byte_valid_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;
    if (w_fall) begin
      case (r_state)
        RX_IDLE:   if (!r_dat_s2) w_state_nxt = RX_DATA;
        RX_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
        RX_PARITY: w_state_nxt = RX_STOP;
        RX_STOP: begin
          w_state_nxt = RX_IDLE;
          if (r_dat_s2 && r_par_ok) w_byte_valid_nxt  = 1'b1;
          else                      w_frame_error_nxt = 1'b1;
        end
        default:   w_state_nxt = RX_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = RX_IDLE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_clk_s1      <= 1'b0;
      r_clk_s2      <= 1'b0;
      r_clk_prev    <= 1'b0;
      r_dat_s1      <= 1'b0;
      r_dat_s2      <= 1'b0;
      r_state       <= RX_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_par_ok      <= 1'b0;
      r_to_cnt      <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of its neighbours.
      r_clk_s1      <= i_ps2_clk;
      r_clk_s2      <= r_clk_s1;
      r_clk_prev    <= r_clk_s2;
      r_dat_s1      <= i_ps2_dat;
      r_dat_s2      <= r_dat_s1;
      r_state       <= w_state_nxt;
      r_byte_valid  <= w_byte_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
      if (w_fall) begin
        case (r_state)
          RX_IDLE:   r_bit_cnt <= 3'd0;
          RX_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          RX_PARITY: r_par_ok <= ^{r_shift, r_dat_s2};
          default:   ;
        endcase
      end
      // Counter only runs mid-frame and restarts on each PS/2 edge.
      if (w_fall || r_state == RX_IDLE) r_to_cnt <= '0;
      else if (!w_timeout)              r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign o_byte_valid  = r_byte_valid;
  assign o_byte_data   = r_shift;
  assign o_frame_error = r_frame_error;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 make-code decoder: strips E0/F0 prefixes and strobes each make code.
// Optional REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_extended,
  output logic       frame_error
);

  logic        w_byte_valid, w_frame_error;
  logic [7:0]  w_byte_data;
  byte_state_t r_state, w_state_nxt;
  logic        w_make, w_ext, w_strobe;
  logic        r_key_pressed, r_key_ext;
  logic [7:0]  r_key_data;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_frame_rx (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_ps2_clk     (ps2_clk),
    .i_ps2_dat     (ps2_dat),
    .o_byte_valid  (w_byte_valid),
    .o_byte_data   (w_byte_data),
    .o_frame_error (w_frame_error)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_ext       = (r_state == B_E0) || (r_state == B_E0F0);
    if (w_frame_error) begin
      w_state_nxt = B_IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        B_IDLE: begin
          if      (w_byte_data == PS2_PREFIX_EXT) w_state_nxt = B_E0;
          else if (w_byte_data == PS2_PREFIX_BRK) w_state_nxt = B_F0;
          else                                    w_make      = 1'b1;
        end
        B_E0: begin
          if      (w_byte_data == PS2_PREFIX_BRK) w_state_nxt = B_E0F0;
          else if (w_byte_data != PS2_PREFIX_EXT) begin
            w_make      = 1'b1;
            w_state_nxt = B_IDLE;
          end
        end
        default: w_state_nxt = B_IDLE;  // break code swallowed
      endcase
    end
  end

`ifdef REPEAT_FILTER_EN
  logic       r_held;
  logic [8:0] r_held_key;
  logic       w_brk, w_match;

  assign w_brk    = w_byte_valid && !w_frame_error &&
                    (r_state == B_F0 || r_state == B_E0F0);
  assign w_match  = r_held && (r_held_key == {w_ext, w_byte_data});
  assign w_strobe = w_make && !w_match;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_held     <= 1'b0;
      r_held_key <= 9'd0;
    end else if (w_strobe) begin
      r_held     <= 1'b1;
      r_held_key <= {w_ext, w_byte_data};
    end else if (w_brk && w_match) begin
      r_held     <= 1'b0;
    end
  end
`else
  assign w_strobe = w_make;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= B_IDLE;
      r_key_pressed <= 1'b0;
      r_key_data    <= 8'h00;
      r_key_ext     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_key_pressed <= w_strobe;
      if (w_strobe) begin
        r_key_data <= w_byte_data;
        r_key_ext  <= w_ext;
      end
    end
  end

  assign ps2_key_pressed  = r_key_pressed;
  assign ps2_key_data     = r_key_data;
  assign ps2_key_extended = r_key_ext;
  assign frame_error      = w_frame_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; expectations follow REPEAT_FILTER_EN when defined.
module tb_ps2_key_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       ps2_key_extended;
  logic       frame_error;

  int checks = 0;
  int passes = 0;
  int n_press = 0;
  int n_err = 0;
  int pi, ei, p0, e0;

  ps2_key_decoder dut (
    .clock            (clock),
    .reset            (reset),
    .ps2_clk          (ps2_clk),
    .ps2_dat          (ps2_dat),
    .ps2_key_pressed  (ps2_key_pressed),
    .ps2_key_data     (ps2_key_data),
    .ps2_key_extended (ps2_key_extended),
    .frame_error      (frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ps2_key_pressed) n_press <= n_press + 1;
    if (frame_error)     n_err   <= n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clock);
    ps2_dat = v;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  // Full frame; reports the cycle index (1-based, posedges after the stop-bit
  // falling edge is driven) at which pressed / frame_error were first seen.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            output int p_idx, output int e_idx);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    @(negedge clock);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b0;
    p_idx = -1;
    e_idx = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      if (ps2_key_pressed && p_idx < 0) p_idx = k;
      if (frame_error && e_idx < 0)     e_idx = k;
    end
    @(negedge clock);
    repeat (2) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic snap();
    @(negedge clock);
    p0 = n_press;
    e0 = n_err;
  endtask

  initial begin
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_pressed", ps2_key_pressed, 0);
    check("rst_data", ps2_key_data, 8'h00);
    check("rst_ext", ps2_key_extended, 0);
    check("rst_ferr", frame_error, 0);

    // Plain make with latency check
    snap();
    send_frame(8'h1D, 1'b0, pi, ei);
    @(negedge clock);
    check("1d_latency", pi, 4);
    check("1d_strobes", n_press - p0, 1);
    check("1d_data", ps2_key_data, 8'h1D);
    check("1d_ext", ps2_key_extended, 0);
    check("1d_noerr", n_err - e0, 0);

    // Break
    snap();
    send_frame(8'hF0, 1'b0, pi, ei);
    send_frame(8'h1D, 1'b0, pi, ei);
    @(negedge clock);
    check("brk_strobes", n_press - p0, 0);
    check("brk_data", ps2_key_data, 8'h1D);

    // Extended make, then extended break
    snap();
    send_frame(8'hE0, 1'b0, pi, ei);
    send_frame(8'h75, 1'b0, pi, ei);
    @(negedge clock);
    check("ext_strobes", n_press - p0, 1);
    check("ext_data", ps2_key_data, 8'h75);
    check("ext_flag", ps2_key_extended, 1);
    snap();
    send_frame(8'hE0, 1'b0, pi, ei);
    send_frame(8'hF0, 1'b0, pi, ei);
    send_frame(8'h75, 1'b0, pi, ei);
    @(negedge clock);
    check("extbrk_strobes", n_press - p0, 0);
    check("extbrk_data", ps2_key_data, 8'h75);

    // Parity error then recovery
    snap();
    send_frame(8'h1D, 1'b1, pi, ei);
    @(negedge clock);
    check("perr_latency", ei, 3);
    check("perr_count", n_err - e0, 1);
    check("perr_strobes", n_press - p0, 0);
    snap();
    send_frame(8'h1C, 1'b0, pi, ei);
    @(negedge clock);
    check("1c_strobes", n_press - p0, 1);
    check("1c_data", ps2_key_data, 8'h1C);
    check("1c_ext", ps2_key_extended, 0);

    // Timeout: abandon a frame after 4 data bits
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (50100) @(negedge clock);
    send_frame(8'h23, 1'b0, pi, ei);
    @(negedge clock);
    check("to_noerr", n_err - e0, 0);
    check("to_strobes", n_press - p0, 1);
    check("to_data", ps2_key_data, 8'h23);

    // Typematic repeats
    snap();
    send_frame(8'h1D, 1'b0, pi, ei);
    send_frame(8'h1D, 1'b0, pi, ei);
    send_frame(8'h1D, 1'b0, pi, ei);
    send_frame(8'hF0, 1'b0, pi, ei);
    send_frame(8'h1D, 1'b0, pi, ei);
    send_frame(8'h1D, 1'b0, pi, ei);
    @(negedge clock);
`ifdef REPEAT_FILTER_EN
    check("rep_strobes", n_press - p0, 2);
`else
    check("rep_strobes", n_press - p0, 4);
`endif
    check("rep_data", ps2_key_data, 8'h1D);

    // Reset mid-frame with an E0 prefix pending
    send_frame(8'hE0, 1'b0, pi, ei);
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mrst_data", ps2_key_data, 8'h00);
    check("mrst_ext", ps2_key_extended, 0);
    check("mrst_strobes", n_press - p0, 0);
    snap();
    send_frame(8'h2B, 1'b0, pi, ei);
    @(negedge clock);
    check("post_rst_strobes", n_press - p0, 1);
    check("post_rst_data", ps2_key_data, 8'h2B);
    check("post_rst_ext", ps2_key_extended, 0);
    check("post_rst_noerr", n_err - e0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Upstream stage of the player-controls key matcher. Deserializes raw PS/2 keyboard clock/data lines into scan-code bytes.
- Strips break (F0) and extended (E0) prefixes and emits a one-cycle ps2_key_pressed strobe with ps2_key_data on each make code.
- Downstream logic compares ps2_key_data against the configured per-player keys only while the strobe is high.

Parameters:
- TIMEOUT_CYCLES, 50000, system-clock cycles with no PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- TIMEOUT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_dat  in  1  raw PS/2 data line, asynchronous.
- ps2_key_pressed  out  1  one-cycle strobe; a make code is valid.
- ps2_key_data  out  8  last make-code byte; holds between strobes.
- ps2_key_extended  out  1  last make code was E0-prefixed; holds with ps2_key_data.
- frame_error  out  1  one-cycle strobe on a parity or stop-bit failure.

Behaviour:
- Reset (synchronous, active-high) clears all outputs, synchronizers, shift register, counters and both FSMs.
  - Outputs after reset: ps2_key_pressed=0, ps2_key_data=8'h00, ps2_key_extended=0, frame_error=0.
  - Reset mid-frame discards the partial frame and any pending prefix.
- Synchronization: ps2_clk and ps2_dat each pass through a 2-FF synchronizer. A falling edge is detected when the previous synced clk=1 and the current synced clk=0.
- Frame FSM (sub-module), states RX_IDLE, RX_DATA, RX_PARITY, RX_STOP; each transition fires on a detected falling edge.
  - RX_IDLE: sample dat. If dat=0 (start bit), go to RX_DATA with bit count 0. If dat=1, stay in RX_IDLE with no error.
  - RX_DATA: shift 8 bits, LSB first. After the 8th bit, go to RX_PARITY.
  - RX_PARITY: sample the parity bit. Odd parity is required: the 8 data bits plus parity contain an odd number of 1s.
  - RX_STOP: sample the stop bit. If stop=1 and parity was OK, pulse byte_valid with the byte. Otherwise pulse frame_error. Either way return to RX_IDLE.
  - Timeout: the counter runs in any state other than RX_IDLE and clears on every falling edge. On reaching TIMEOUT_CYCLES, return to RX_IDLE silently with no frame_error.
- Byte FSM, states B_IDLE, B_E0, B_F0, B_E0F0; acts on byte_valid.
  - B_IDLE: E0 goes to B_E0. F0 goes to B_F0. Any other byte is a make: emit it with extended=0.
  - B_E0: F0 goes to B_E0F0. E0 stays in B_E0. Any other byte is a make: emit it with extended=1, then go to B_IDLE.
  - B_F0: any byte is swallowed as a break, then go to B_IDLE.
  - B_E0F0: any byte is swallowed as a break, then go to B_IDLE.
  - frame_error forces the byte FSM to B_IDLE.
- Emit: ps2_key_data and ps2_key_extended are registered, and ps2_key_pressed is high for exactly one cycle.
- Latency: ps2_key_pressed rises exactly 2 clock cycles after the cycle in which the stop-bit falling edge is detected. frame_error rises 1 cycle after that edge.
- No two strobes are ever closer than one PS/2 frame, so no back-to-back conflict exists.

Optional Feature:
- Macro: REPEAT_FILTER_EN.
- Defined:
  - Track the held key as {extended, code} plus a held flag.
  - A make matching the held key while held=1 (typematic repeat) is swallowed with no strobe.
  - A break matching the held key clears held.
  - A different make strobes and replaces the held key.
  - Reset clears held.
- Undefined: every make code strobes, including repeats.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - the enums for frame and byte FSM states.
- Sub-module ps2_frame_rx: synchronizers, edge detect, frame FSM and timeout. It outputs byte_valid, byte_data and frame_error to the byte FSM in ps2_key_decoder.

Test Plan:
- Frame 1D (odd parity bit 1) -> one strobe, ps2_key_data=8'h1D, ps2_key_extended=0, 2 cycles after the stop edge.
- Frames F0,1D following a 1D make -> no strobe; ps2_key_data stays 8'h1D.
- Frames E0,75 -> strobe with data 8'h75, extended=1. Then E0,F0,75 -> no strobe.
- Frame 1D with the parity bit flipped -> frame_error pulses once, no strobe. A following valid 1C -> strobe with data 8'h1C.
- Stop after 4 data bits for more than 50000 cycles, then send a full valid 23 -> no error, strobe with data 8'h23.
- 1D,1D,1D then F0,1D then 1D:
  - With REPEAT_FILTER_EN: strobes on the 1st and 5th 1D only.
  - Without: strobes on all four makes.
  - Also assert reset mid-frame -> no strobe, and a subsequent frame decodes correctly.
